// File: rtl/inv_rr_arbiter.sv
// Round-robin arbiter sharing one external inverter bank among N_REQ requesters.
// Define INV_RR_ARBITER_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module inv_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    localparam int IW   = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]       inv_a,
    input  logic [WIDTH-1:0]       inv_y,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [IW-1:0]          rsp_id
);

    logic          stall;
    logic          hit;
    logic          grant;
    logic [IW-1:0] win;
    int            idx;

`ifndef INV_RR_ARBITER_FIXED_PRIO_EN
    logic [IW-1:0] ptr;
`endif

    assign stall = rsp_valid & ~rsp_ready;

    // First valid requester, scanning upward from the priority pointer.
    always_comb begin
        hit = 1'b0;
        win = '0;
        idx = 0;
        for (int k = 0; k < N_REQ; k++) begin
`ifdef INV_RR_ARBITER_FIXED_PRIO_EN
            idx = k;
`else
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
`endif
            if (!hit && req_valid[IW'(idx)]) begin
                hit = 1'b1;
                win = IW'(idx);
            end
        end
    end

    // Reset suppresses the grant so nothing in flight is captured.
    assign grant = hit & ~stall & ~rst;

    always_comb begin
        req_ready = '0;
        inv_a     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant && win == IW'(i)) begin
                req_ready[i] = 1'b1;
                inv_a        = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else if (grant) begin
            rsp_valid <= 1'b1;
            rsp_data  <= inv_y;
            rsp_id    <= win;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifndef INV_RR_ARBITER_FIXED_PRIO_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant) begin
            ptr <= (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_inv_rr_arbiter.sv
// Self-checking bench for inv_rr_arbiter: directed steps then random traffic
// against a spec-level reference model; inverter bank modelled as ~inv_a.
module tb_inv_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   inv_a;
    logic [W-1:0]   inv_y;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_data;
    logic [IW-1:0]  rsp_id;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int       m_ptr  = 0;
    bit       m_vld  = 1'b0;
    bit [W-1:0] m_data = '0;
    int       m_id   = 0;
    bit       m_init = 1'b0;

    always #5 clk = ~clk;

    assign inv_y = ~inv_a;

    inv_rr_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .inv_a     (inv_a),
        .inv_y     (inv_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (p + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic step(input logic r, input logic [N-1:0] v,
                        input logic [N*W-1:0] d, input logic rr);
        int w;
        logic [N-1:0] e_rdy;
        logic [W-1:0] e_a;
        rst       = r;
        req_valid = v;
        req_data  = d;
        rsp_ready = rr;
        @(negedge clk);
        w = (r || (m_vld && !rr)) ? -1 : pick(v, m_ptr);
        e_rdy = '0;
        e_a   = '0;
        if (w >= 0) begin
            e_rdy[w] = 1'b1;
            e_a      = d[w*W +: W];
        end
        chk("req_ready", 32'(req_ready), 32'(e_rdy));
        chk("inv_a", 32'(inv_a), 32'(e_a));
        if (m_init) begin
            chk("rsp_valid", 32'(rsp_valid), 32'(m_vld));
            chk("rsp_data", 32'(rsp_data), 32'(m_data));
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
        end
        @(posedge clk);
        if (r) begin
            m_ptr  = 0;
            m_vld  = 1'b0;
            m_data = '0;
            m_id   = 0;
            m_init = 1'b1;
        end else if (w >= 0) begin
            m_data = ~d[w*W +: W];
            m_id   = w;
            m_vld  = 1'b1;
`ifdef INV_RR_ARBITER_FIXED_PRIO_EN
            m_ptr  = 0;
`else
            m_ptr  = (w + 1) % N;
`endif
        end else if (rr) begin
            m_vld = 1'b0;
        end
        #1;
    endtask

    localparam logic [N*W-1:0] D4 = {8'hFF, 8'hAA, 8'h55, 8'h00};

    initial begin
        logic [N*W-1:0] rd;

        step(1'b1, 4'b1111, D4, 1'b1);
        step(1'b1, 4'b1111, D4, 1'b1);
        chk("reset_rsp", {rsp_valid, 6'(rsp_id), rsp_data}, 32'h0);

        // Single requester: accept in T, result in T+1
        step(1'b0, 4'b0001, 32'h0000_000F, 1'b1);
        chk("tp1_rsp", {rsp_valid, 6'(rsp_id), rsp_data}, {1'b1, 6'd0, 8'hF0});
        step(1'b0, 4'b0000, '0, 1'b1);

        // All valid: fairness rotation
        for (int i = 0; i < 6; i++) step(1'b0, 4'b1111, D4, 1'b1);

        // Grant to 2 moves ptr to 3, then only 0 and 1 valid
        step(1'b0, 4'b0100, D4, 1'b1);
        step(1'b0, 4'b0011, D4, 1'b1);
        step(1'b0, 4'b0011, D4, 1'b1);

        // Stall for three cycles, then release
        step(1'b0, 4'b1111, D4, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 4'b1111, D4, 1'b0);
        step(1'b0, 4'b1111, D4, 1'b1);
        step(1'b0, 4'b1111, D4, 1'b1);

        // Reset with a pending response and live requests
        step(1'b0, 4'b1110, D4, 1'b0);
        step(1'b1, 4'b1111, D4, 1'b0);
        step(1'b0, 4'b1111, D4, 1'b1);
        chk("post_rst_id", 32'(rsp_id), 32'd0);

        // No requests: response drains once consumer is ready
        step(1'b0, 4'b0000, D4, 1'b0);
        step(1'b0, 4'b0000, D4, 1'b0);
        step(1'b0, 4'b0000, D4, 1'b1);
        step(1'b0, 4'b0000, D4, 1'b1);

        for (int i = 0; i < 400; i++) begin
            rd = {$urandom};
            step(($urandom_range(0, 49) == 0), 4'($urandom), rd,
                 ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inv_rr_arbiter.md
# inv_rr_arbiter

Round-robin arbiter that shares one WIDTH-bit inverter datapath (WIDTH parallel `inv` cells, ports A/Y, instantiated outside this block) among N_REQ requesters. Each requester offers an operand with a valid/ready handshake. The arbiter grants at most one per cycle, steers the winner's operand onto the shared inverter input, and registers the inverted result with the winner's index. A single response port with backpressure returns results. The block sits between the requesting logic and the shared inverter bank.

## Interface
- `N_REQ`, 4: number of requesters, 2..8
- `WIDTH`, 8: operand width in bits
- `clk` in 1: sole clock; all state updates on rising edge
- `rst` in 1: reset; synchronous, active-high
- `req_valid` in N_REQ: bit i set = requester i offers an operand
- `req_data` in N_REQ*WIDTH: operand i at bits [i*WIDTH +: WIDTH]
- `req_ready` out N_REQ: one-hot or zero; bit i = requester i accepted this cycle
- `inv_a` out WIDTH: drive to shared inverter inputs A
- `inv_y` in WIDTH: shared inverter outputs Y, combinational from `inv_a`
- `rsp_valid` out 1: response holds a result
- `rsp_ready` in 1: consumer takes the response
- `rsp_data` out WIDTH: inverted operand
- `rsp_id` out clog2(N_REQ): index of the requester that owns `rsp_data`

## Operation
- State:
  - priority pointer `ptr` (clog2(N_REQ) bits)
  - response register (`rsp_valid`, `rsp_data`, `rsp_id`)
- `stall` = `rsp_valid` & ~`rsp_ready`.
- Grant, combinational:
  - If ~`stall`, the winner is the first i with `req_valid[i]=1`, searching `ptr`, `ptr`+1, … with wrap modulo N_REQ.
  - `req_ready` is one-hot on the winner.
  - With no valid requests, or during `stall`, `req_ready`=0.
- A transfer occurs when `req_valid[i]` & `req_ready[i]`. At most one transfer per cycle.
- Datapath:
  - On a transfer, `inv_a` = winner's operand. Otherwise `inv_a` = 0.
  - On a transfer, on the next edge: `rsp_data` <= `inv_y`, `rsp_id` <= winner, `rsp_valid` <= 1, `ptr` <= (winner+1) mod N_REQ.
- Response:
  - Held stable while `rsp_valid` & ~`rsp_ready`.
  - If `rsp_ready`=1 and there is no new transfer, `rsp_valid` <= 0.
  - If `rsp_ready`=1 and there is a new transfer, the register is reloaded in the same edge, giving back-to-back throughput.
- Arithmetic: `rsp_data` is the bitwise NOT of the operand. No width extension.
- Pointer wraps from N_REQ-1 to 0.
- `ptr` is unchanged in cycles without a transfer.
- Requesters must hold `req_valid`/`req_data` until accepted. The arbiter does not require this for correctness; it samples only in the transfer cycle.

## Timing
- Reset values: `ptr`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0.
- Combinational outputs while `rst` is high: `req_ready`=0 and `inv_a`=0.
- Latency: operand accepted in cycle T → `rsp_valid`=1 with its result in cycle T+1.
- Throughput: 1 result/cycle while `rsp_ready`=1.
- Fairness: with all requesters continuously valid, grants are 0,1,…,N_REQ-1,0,…
- Boundary conditions:
  - **Single active requester:** granted every non-stalled cycle.
  - **Stall:** all `req_ready`=0, `ptr` frozen, `inv_a`=0, response unchanged.
  - **Stall release:** in the cycle `rsp_ready` rises, arbitration resumes. A new grant in that cycle replaces the response at the edge.
  - **Reset mid-operation:** the pending response is discarded (`rsp_valid`=0 next cycle), `ptr`=0, and the in-flight grant is ignored.
  - **Reset and transfer in the same cycle:** reset wins.

## Configuration
- Macro `INV_RR_ARBITER_FIXED_PRIO_EN`.
- Defined: fixed priority. The lowest valid index always wins, `ptr` is held at 0, and the rotation logic is omitted. Starvation of higher indices is permitted.
- Undefined (default): round-robin as specified above.

## Test plan
- Reset, then `req_valid`=4'b0001, operand0=8'h0F → `req_ready`=4'b0001 in T; `rsp_valid`=1, `rsp_data`=8'hF0, `rsp_id`=0 in T+1.
- All four valid continuously, operands 8'h00/8'h55/8'hAA/8'hFF, `rsp_ready`=1:
  - Grant sequence 0,1,2,3,0.
  - Responses FF/AA/55/00 with matching ids.
  - With the macro defined, requester 0 is granted every cycle.
- `ptr`=3 (after a grant to 2), then only requesters 0 and 1 valid → requester 0 granted, then 1.
- `rsp_ready`=0 for 3 cycles with requesters valid:
  - `req_ready`=0 and response held constant throughout.
  - On `rsp_ready`=1, the next requester in order is granted and a new response appears the following cycle.
- `rst`=1 while `rsp_valid`=1 and requests pending → next cycle `rsp_valid`=0, `ptr`=0. After release, requester 0 wins first.
- No requests → `inv_a`=8'h00, `req_ready`=0, `rsp_valid` drops one cycle after `rsp_ready`.
